// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StRun,
    StSwrst,
    StAck
  } state_e;

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Software-reset handshake and sequenced reset outputs of one clock domain.
interface rst_sequencer_if #(
  parameter int unsigned NUM_OUT = 4
);
  logic               sw_rst_req;
  logic               sw_rst_ack;
  logic               rst_sync;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready;

  modport master (
    input  sw_rst_req,
    output sw_rst_ack,
    output rst_sync,
    output rst_out,
    output ready
  );

  modport slave (
    output sw_rst_req,
    input  sw_rst_ack,
    input  rst_sync,
    input  rst_out,
    input  ready
  );
endinterface

// File: rtl/rst_sync_cell.sv
// Reset synchronizer: asynchronous assertion, deassertion after STAGES clock edges.
module rst_sync_cell #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronized release, hold stretch, staggered per-output release and
// a four-phase software reset handshake.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  rst_sequencer_if.master bus
);

  localparam int unsigned CntW = max($clog2(max(HOLD_CYCLES, STEP_CYCLES)), 1);
  localparam int unsigned IdxW = max($clog2(NUM_OUT), 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StepLast = CntW'(STEP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               ack_q, ack_d;
  logic               rst_sync_w;

  rst_sync_cell #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rst_sync_o(rst_sync_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHold;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    ack_d     = ack_q;
    unique case (state_q)
      StHold: begin
        // The stretch only starts counting once the synchronized reset has dropped.
        if (rst_sync_w) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          cnt_d        = '0;
          rst_out_d[0] = 1'b0;
          idx_d        = IdxW'(1);
          if (NUM_OUT == 1) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_q == StepLast) begin
          cnt_d     = '0;
          rst_out_d = rst_out_q & ~(NUM_OUT'(1) << idx_q);
          idx_d     = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (bus.sw_rst_req) begin
          state_d   = StSwrst;
          rst_out_d = '1;
          ready_d   = 1'b0;
          cnt_d     = '0;
        end
      end
      StSwrst: begin
        if (cnt_q == HoldLast) begin
          state_d = StAck;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        if (!bus.sw_rst_req) begin
          state_d = StHold;
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StHold;
      end
    endcase
  end

  always_comb begin
    bus.rst_sync   = rst_sync_w;
    bus.rst_out    = rst_out_q;
    bus.ready      = ready_q;
    bus.sw_rst_ack = ack_q;
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance plus a NUM_OUT=1/HOLD=1/SYNC=3 corner instance.
`timescale 1ns/100ps
module tb_rst_sequencer;

  typedef struct {
    int          e;
    logic [3:0]  out;
    logic        rdy;
    logic        sync;
    logic        ack;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   base_a = 0;
  int   base_b = 0;
  int   checks = 0;
  int   failures = 0;

  vec_t pon_tbl[11];
  vec_t sw_tbl[11];
  vec_t cor_tbl[5];
  vec_t qa[$];
  vec_t qb[$];

  rst_sequencer_if #(.NUM_OUT(4)) ifa ();
  rst_sequencer_if #(.NUM_OUT(1)) ifb ();

  rst_sequencer u_dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(ifa)
  );

  rst_sequencer #(
    .SYNC_STAGES(3),
    .NUM_OUT    (1),
    .HOLD_CYCLES(1),
    .STEP_CYCLES(4)
  ) u_dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input int e, input logic [3:0] out, input logic rdy,
                              input logic sync, input logic ack, input string name);
    vec_t v;
    v.e = e; v.out = out; v.rdy = rdy; v.sync = sync; v.ack = ack; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: an expected record is consumed on the falling edge after its rising edge.
  always @(negedge clk) begin
    vec_t v;
    if (qa.size() > 0 && (cyc - base_a) == qa[0].e) begin
      v = qa.pop_front();
      chk({v.name, ".rst_out"}, 32'(ifa.rst_out), 32'(v.out));
      chk({v.name, ".ready"}, 32'(ifa.ready), 32'(v.rdy));
      chk({v.name, ".rst_sync"}, 32'(ifa.rst_sync), 32'(v.sync));
      chk({v.name, ".ack"}, 32'(ifa.sw_rst_ack), 32'(v.ack));
    end
    if (qb.size() > 0 && (cyc - base_b) == qb[0].e) begin
      v = qb.pop_front();
      chk({v.name, ".rst_out"}, 32'(ifb.rst_out), 32'(v.out));
      chk({v.name, ".ready"}, 32'(ifb.ready), 32'(v.rdy));
      chk({v.name, ".rst_sync"}, 32'(ifb.rst_sync), 32'(v.sync));
      chk({v.name, ".ack"}, 32'(ifb.sw_rst_ack), 32'(v.ack));
    end
  end

  task automatic push_pon(input int lim);
    for (int i = 0; i < 11; i++) if (pon_tbl[i].e <= lim) qa.push_back(pon_tbl[i]);
  endtask

  task automatic wait_rel_a(input int n);
    while ((cyc - base_a) < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".rst_out"}, 32'(ifa.rst_out), 32'hF);
    chk({tag, ".ready"}, 32'(ifa.ready), 32'd0);
    chk({tag, ".rst_sync"}, 32'(ifa.rst_sync), 32'd1);
    chk({tag, ".ack"}, 32'(ifa.sw_rst_ack), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pon_tbl[0]  = mk(1,  4'hF, 0, 1, 0, "pon_e1");
    pon_tbl[1]  = mk(2,  4'hF, 0, 0, 0, "pon_e2");
    pon_tbl[2]  = mk(17, 4'hF, 0, 0, 0, "pon_e17");
    pon_tbl[3]  = mk(18, 4'hE, 0, 0, 0, "pon_e18");
    pon_tbl[4]  = mk(21, 4'hE, 0, 0, 0, "pon_e21");
    pon_tbl[5]  = mk(22, 4'hC, 0, 0, 0, "pon_e22");
    pon_tbl[6]  = mk(25, 4'hC, 0, 0, 0, "pon_e25");
    pon_tbl[7]  = mk(26, 4'h8, 0, 0, 0, "pon_e26");
    pon_tbl[8]  = mk(29, 4'h8, 0, 0, 0, "pon_e29");
    pon_tbl[9]  = mk(30, 4'h0, 1, 0, 0, "pon_e30");
    pon_tbl[10] = mk(31, 4'h0, 1, 0, 0, "pon_e31");

    sw_tbl[0]  = mk(0,  4'hF, 0, 0, 0, "sw_r0");
    sw_tbl[1]  = mk(15, 4'hF, 0, 0, 0, "sw_r15");
    sw_tbl[2]  = mk(16, 4'hF, 0, 0, 1, "sw_r16");
    sw_tbl[3]  = mk(19, 4'hF, 0, 0, 1, "sw_r19");
    sw_tbl[4]  = mk(20, 4'hF, 0, 0, 0, "sw_r20");
    sw_tbl[5]  = mk(35, 4'hF, 0, 0, 0, "sw_r35");
    sw_tbl[6]  = mk(36, 4'hE, 0, 0, 0, "sw_r36");
    sw_tbl[7]  = mk(40, 4'hC, 0, 0, 0, "sw_r40");
    sw_tbl[8]  = mk(44, 4'h8, 0, 0, 0, "sw_r44");
    sw_tbl[9]  = mk(47, 4'h8, 0, 0, 0, "sw_r47");
    sw_tbl[10] = mk(48, 4'h0, 1, 0, 0, "sw_r48");

    cor_tbl[0] = mk(1, 4'h1, 0, 1, 0, "cor_e1");
    cor_tbl[1] = mk(2, 4'h1, 0, 1, 0, "cor_e2");
    cor_tbl[2] = mk(3, 4'h1, 0, 0, 0, "cor_e3");
    cor_tbl[3] = mk(4, 4'h0, 1, 0, 0, "cor_e4");
    cor_tbl[4] = mk(6, 4'h0, 1, 0, 0, "cor_e6");

    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.sw_rst_req = 1'b0;
    ifb.sw_rst_req = 1'b0;

    // Power-on release of both instances.
    repeat (5) @(negedge clk);
    #1;
    chk_reset_a("por");
    chk("por_b.rst_out", 32'(ifb.rst_out), 32'h1);
    chk("por_b.ready", 32'(ifb.ready), 32'd0);
    chk("por_b.rst_sync", 32'(ifb.rst_sync), 32'd1);
    base_a = cyc;
    base_b = cyc;
    push_pon(100);
    for (int i = 0; i < 5; i++) qb.push_back(cor_tbl[i]);
    rst_a = 1'b0;
    rst_b = 1'b0;
    drain(60);

    // Reset reasserted between E23 and E24, then a full restart.
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    base_a = cyc;
    push_pon(22);
    rst_a = 1'b0;
    wait_rel_a(23);
    rst_a = 1'b1;
    #1;
    chk_reset_a("midseq");
    drain(5);
    repeat (2) @(negedge clk);
    #1;
    base_a = cyc;
    push_pon(100);
    rst_a = 1'b0;
    drain(60);

    // Software reset handshake from RUN; R is relative edge 0.
    ifa.sw_rst_req = 1'b1;
    base_a = cyc + 1;
    for (int i = 0; i < 11; i++) qa.push_back(sw_tbl[i]);
    wait_rel_a(19);
    ifa.sw_rst_req = 1'b0;
    drain(60);

    // 1 ns glitch on rst while in RUN.
    rst_a = 1'b1;
    #1;
    rst_a = 1'b0;
    #0.5;
    chk_reset_a("glitch");
    base_a = cyc;
    push_pon(100);
    drain(60);

    // Request raised during HOLD must be ignored.
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    base_a = cyc;
    push_pon(100);
    rst_a = 1'b0;
    wait_rel_a(5);
    ifa.sw_rst_req = 1'b1;
    wait_rel_a(12);
    chk("ign_hold.ack", 32'(ifa.sw_rst_ack), 32'd0);
    chk("ign_hold.rst_out", 32'(ifa.rst_out), 32'hF);
    ifa.sw_rst_req = 1'b0;
    drain(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset controller that turns one raw asynchronous reset into a clean, ordered set of block resets. Assertion is immediate and asynchronous. Release is synchronized to `clk`, stretched, then staggered one output at a time. It also runs a four-phase software-reset handshake. It sits at the top of each clock domain and drives the `rst` of downstream logic, both synchronous-reset and asynchronous-reset flops.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth, must be ≥2
- `NUM_OUT`, 4: number of sequenced reset outputs, must be ≥1
- `HOLD_CYCLES`, 16: stretch after synchronized release, must be ≥1
- `STEP_CYCLES`, 4: gap between successive output releases, must be ≥1

Ports:
- `clk`  in  1  domain clock
- `rst`  in  1  raw reset; asynchronous, active-high
- `sw_rst_req`  in  1  software reset request, level, synchronous to `clk`
- `sw_rst_ack`  out  1  software reset acknowledge
- `rst_sync`  out  1  synchronized reset: async assert, sync deassert
- `rst_out`  out  NUM_OUT  sequenced resets, active-high; bit 0 releases first
- `ready`  out  1  all outputs released

## Operation
- **Reset values** (asynchronous on `rst`=1):
  - `rst_sync`=1, `rst_out`=all 1s, `ready`=0, `sw_rst_ack`=0
  - state=HOLD, counter=0, idx=0
- **Synchronizer:** `SYNC_STAGES` flops, all async-set by `rst`. Each shifts in 0 per edge. `rst_sync` is the last stage.
- **HOLD:**
  - Counter is held at 0 while `rst_sync`=1.
  - Otherwise it increments each edge.
  - At the edge where counter==HOLD_CYCLES-1: counter←0, `rst_out[0]`←0, idx←1, state←RELEASE.
  - If NUM_OUT==1, go directly to RUN and set `ready`←1 on that edge.
- **RELEASE:**
  - Counter increments each edge.
  - At the edge where counter==STEP_CYCLES-1: counter←0, `rst_out[idx]`←0, idx++.
  - On the edge that clears bit NUM_OUT-1: state←RUN, `ready`←1.
- **RUN:** outputs stable. `sw_rst_req`=1 sampled at an edge gives, on that edge:
  - state←SWRST, `rst_out`←all 1s, `ready`←0, counter←0.
- **SWRST:**
  - Counter increments.
  - At counter==HOLD_CYCLES-1: state←ACK, `sw_rst_ack`←1, counter←0.
- **ACK:**
  - Hold until `sw_rst_req`=0 is sampled.
  - Then `sw_rst_ack`←0, state←HOLD, counter←0. The normal stretch and sequence follow.
- **`sw_rst_req` outside RUN/ACK is ignored.** The requester must keep the request high until it sees the ack.
- **`rst` asserted in any state** (mid-stretch, mid-sequence, mid-handshake): all outputs return to their reset values immediately. The counter is discarded.
- **Width rules:**
  - Counter width is `$clog2(max(HOLD_CYCLES,STEP_CYCLES))`, minimum 1.
  - idx width is `$clog2(NUM_OUT)`, minimum 1.
  - The counter never wraps: the compare precedes any overflow.
- **Monotonic outputs:** `rst_out` bits only deassert in ascending index order. They only reassert all together (via `rst` or SWRST).

## Timing
- `rst` falls before edge E1, meeting setup: `rst_sync` falls at edge E_S, where S=SYNC_STAGES.
- `rst_out[k]` falls at edge E_(S+HOLD_CYCLES+k·STEP_CYCLES).
- `ready` rises on the same edge as `rst_out[NUM_OUT-1]`.
- With defaults: `rst_sync`@E2, `rst_out[0]`@E18, `[1]`@E22, `[2]`@E26, `[3]`@E30, `ready`@E30.
- **Software reset:**
  - The edge sampling the request asserts `rst_out`.
  - `sw_rst_ack` rises HOLD_CYCLES edges later.
  - After the edge sampling the request low, release follows the same HOLD + step schedule measured from that edge.
- All outputs are registered. There is no combinational path from `sw_rst_req` to any output.
- `rst` assertion reaches every output with no clock required.

## Structure
- Package `rst_seq_pkg`:
  - state enum: HOLD, RELEASE, RUN, SWRST, ACK
  - `max` helper function for counter sizing
- Sub-module `rst_sync_cell`: parameterized async-assert/sync-deassert chain, depth `SYNC_STAGES`.
- Top-level FSM, counter, idx and output registers: all in one always block with async reset on `rst`.

## Test plan
- **Power-on release (defaults):** `rst` high 5 cycles, dropped before E1.
  - Required: `rst_sync` 0@E2; `rst_out` 4'b1110@E18, 4'b1100@E22, 4'b1000@E26, 4'b0000@E30; `ready`=1@E30.
- **Reset mid-sequence:** reassert `rst` asynchronously between E23 and E24.
  - Required: `rst_out`=4'hF, `ready`=0, `rst_sync`=1 before the next edge.
  - After release, the full schedule restarts from E1.
- **Software reset:** in RUN, raise `sw_rst_req` at edge R.
  - Required: `rst_out`=4'hF@R, `ready`=0, `sw_rst_ack`=1@R+16.
  - Drop the request at R+20: ack 0@R+20, `rst_out[0]` 0@R+36, `ready`@R+48.
- **Ignored request:** `sw_rst_req`=1 during HOLD.
  - Required: schedule unchanged, `sw_rst_ack` stays 0.
- **Glitch reset:** 1 ns `rst` pulse between edges in RUN.
  - Required: all outputs reassert asynchronously; the full release sequence follows.
- **Parameter corner:** NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3.
  - Required: `rst_sync` 0@E3, `rst_out`=0 and `ready`=1@E4.
